// File: rtl/minterm_sweep_checker_if.sv
// rtl/minterm_sweep_checker_if.sv - stimulus/result bundle between the minterm sweep checker and its environment
interface minterm_sweep_checker_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [N_IN-1:0]      vec;
  logic                 resp;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_count;
  logic                 first_fail_valid;
  logic [N_IN-1:0]      first_fail_idx;
  logic [2**N_IN-1:0]   obs_table;

  modport master (
    input  start, resp,
    output vec, busy, done, pass, err_count, first_fail_valid, first_fail_idx, obs_table
  );

  modport slave (
    output start, resp,
    input  vec, busy, done, pass, err_count, first_fail_valid, first_fail_idx, obs_table
  );
endinterface

// File: rtl/minterm_sweep_checker.sv
// rtl/minterm_sweep_checker.sv - exhaustive input sweep and truth-table check of a combinational block
// Optional macro SWEEP_GRAY_EN: sweep in reflected Gray order instead of binary order.
module minterm_sweep_checker #(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'b0111_1111
) (
  input  logic                      clk,
  input  logic                      rst_n,
  minterm_sweep_checker_if.master   bus
);
  localparam int              NV          = 2**N_IN;
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_STEP   = '1;
  localparam logic [N_IN-1:0] STEP_ONE    = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);
  localparam logic [N_IN:0]   ERR_MAX     = (N_IN+1)'(NV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [N_IN-1:0] step;
  logic [N_IN-1:0] step_next;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Maps the sweep position to the vector actually driven onto the block under test.
  function automatic logic [N_IN-1:0] seq_vec(input logic [N_IN-1:0] k);
`ifdef SWEEP_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  always_comb begin
    step_next = step + STEP_ONE;
    mismatch  = (bus.resp != EXPECTED[bus.vec]);
    err_next  = bus.err_count;
    if (mismatch && (bus.err_count != ERR_MAX)) begin
      err_next = bus.err_count + ERR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      step                 <= '0;
      bus.vec              <= '0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.pass             <= 1'b0;
      bus.err_count        <= '0;
      bus.first_fail_valid <= 1'b0;
      bus.first_fail_idx   <= '0;
      bus.obs_table        <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state                <= ST_SETTLE;
            cnt                  <= SETTLE_LOAD;
            step                 <= '0;
            bus.vec              <= seq_vec('0);
            bus.busy             <= 1'b1;
            bus.done             <= 1'b0;
            bus.pass             <= 1'b0;
            bus.err_count        <= '0;
            bus.first_fail_valid <= 1'b0;
            bus.first_fail_idx   <= '0;
            bus.obs_table        <= '0;
          end
        end

        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_SAMPLE: begin
          bus.obs_table[bus.vec] <= bus.resp;
          bus.err_count          <= err_next;
          if (mismatch && !bus.first_fail_valid) begin
            bus.first_fail_valid <= 1'b1;
            bus.first_fail_idx   <= bus.vec;
          end
          // The sweep ends on the last position; vec is left on the final vector.
          if (step == LAST_STEP) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_next == '0);
          end else begin
            state   <= ST_SETTLE;
            step    <= step_next;
            bus.vec <= seq_vec(step_next);
            cnt     <= SETTLE_LOAD;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// tb/tb_minterm_sweep_checker.sv - randomized and directed check of minterm_sweep_checker against a truth-table model
module tb_minterm_sweep_checker;
  localparam int         N_IN = 3;
  localparam int         NV   = 8;
  localparam int         HOLD = 3;
  localparam logic [7:0] EXP  = 8'b0111_1111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dut_tbl;
  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;
  logic [2:0] order [NV];

  minterm_sweep_checker_if #(.N_IN(N_IN)) bus ();

  minterm_sweep_checker #(
    .N_IN    (N_IN),
    .SETTLE  (2),
    .EXPECTED(EXP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural block under test: a truth table chosen by the bench.
  assign bus.resp = dut_tbl[bus.vec];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_vec"},   bus.vec, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_pass"},  bus.pass, 0);
    chk({tag, "_err"},   bus.err_count, 0);
    chk({tag, "_ffv"},   bus.first_fail_valid, 0);
    chk({tag, "_ffi"},   bus.first_fail_idx, 0);
    chk({tag, "_obs"},   bus.obs_table, 0);
  endtask

  task automatic begin_sweep(input logic [7:0] tbl);
    dut_tbl   = tbl;
    bus.start = 1'b1;
    @(negedge clk);
  endtask

  // Called at the falling edge just after the start edge; follows the sweep to DONE.
  task automatic run_sweep(input string tag, input logic [7:0] tbl, input bit noisy);
    int         exp_err;
    bit         exp_ffv;
    logic [2:0] exp_ffi;
    exp_err = $countones(tbl ^ EXP);
    exp_ffv = 1'b0;
    exp_ffi = '0;
    for (int k = 0; k < NV; k++) begin
      if (!exp_ffv && (tbl[order[k]] != EXP[order[k]])) begin
        exp_ffv = 1'b1;
        exp_ffi = order[k];
      end
    end

    chk({tag, "_start_err"}, bus.err_count, 0);
    chk({tag, "_start_obs"}, bus.obs_table, 0);
    chk({tag, "_start_ffv"}, bus.first_fail_valid, 0);
    for (int n = 0; n < NV * HOLD; n++) begin
      chk({tag, "_vec"},  bus.vec, order[n / HOLD]);
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_done"}, bus.done, 0);
      bus.start = noisy && (n < NV * HOLD - 2);
      @(negedge clk);
    end
    chk({tag, "_done_at_24"}, bus.done, 1);
    chk({tag, "_busy_end"},   bus.busy, 0);
    chk({tag, "_pass"},       bus.pass, exp_err == 0);
    chk({tag, "_err"},        bus.err_count, exp_err);
    chk({tag, "_ffv"},        bus.first_fail_valid, exp_ffv);
    chk({tag, "_ffi"},        bus.first_fail_idx, exp_ffi);
    chk({tag, "_obs"},        bus.obs_table, tbl);
    chk({tag, "_vec_last"},   bus.vec, order[NV - 1]);
    repeat (2) @(negedge clk);
    chk({tag, "_hold_done"},  bus.done, 1);
    chk({tag, "_hold_obs"},   bus.obs_table, tbl);
  endtask

  initial begin
    for (int k = 0; k < NV; k++) begin
`ifdef SWEEP_GRAY_EN
      order[k] = 3'(k ^ (k >> 1));
`else
      order[k] = 3'(k);
`endif
    end

    rst_n     = 1'b0;
    bus.start = 1'b1;
    dut_tbl   = EXP;
    repeat (3) @(negedge clk);
    chk_cleared("reset");

    rst_n = 1'b1;
    @(negedge clk);
    run_sweep("nand", EXP, 1'b0);

    begin_sweep(8'hFF);
    run_sweep("stuck1", 8'hFF, 1'b0);

    begin_sweep(8'h5B);
    run_sweep("v2v5", 8'h5B, 1'b0);

    begin_sweep(EXP);
    run_sweep("noisy_start", EXP, 1'b1);

    begin_sweep(8'h00);
    for (int n = 0; n < 10; n++) begin
      bus.start = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_cleared("midreset");
    rst_n = 1'b1;
    begin_sweep(EXP);
    run_sweep("after_reset", EXP, 1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [7:0] t;
      t = 8'($urandom);
      begin_sweep(t);
      run_sweep("random", t, r[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
